// File: rtl/mem_access_arbiter_n.sv
// Arbitrates NUM_CH load/store requesters onto one dmem port, one transaction outstanding.
// Fixed priority by default; define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_access_arbiter_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ORDER_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W/8-1:0] req_rmask,
  input  logic [NUM_CH*DATA_W/8-1:0] req_wmask,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  input  logic [NUM_CH*ORDER_W-1:0]  req_order,
  output logic [NUM_CH-1:0]          resp_valid,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic [ORDER_W-1:0]         resp_order,
  input  logic                       flush_valid,
  input  logic [ORDER_W-1:0]         flush_order,
  output logic [ADDR_W-1:0]          dmem_addr,
  output logic [DATA_W/8-1:0]        dmem_rmask,
  output logic [DATA_W/8-1:0]        dmem_wmask,
  output logic [DATA_W-1:0]          dmem_wdata,
  input  logic [DATA_W-1:0]          dmem_rdata,
  input  logic                       dmem_resp,
  output logic                       busy
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CH_W   = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, WAIT, SQUASH, RESP} state_t;

  state_t             state;
  logic [CH_W-1:0]    cap_ch;
  logic               cap_store;
  logic [ORDER_W-1:0] cap_order;
  logic               cap_flushed;
  logic [NUM_CH-1:0]  eligible;
  logic               grant_any;
  logic [CH_W-1:0]    grant_ch;
  logic [ADDR_W-1:0]  win_addr;
  logic [MASK_W-1:0]  win_rmask;
  logic [MASK_W-1:0]  win_wmask;
  logic [DATA_W-1:0]  win_wdata;
  logic [ORDER_W-1:0] win_order;

  assign cap_flushed = flush_valid && (cap_order > flush_order);
  assign busy        = (state != IDLE);
  assign resp_order  = (state == RESP) ? cap_order : '0;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++)
      eligible[i] = req_valid[i] && !(flush_valid && (req_order[i*ORDER_W +: ORDER_W] > flush_order));
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] last_grant;

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  // Reset value makes the first search start at channel 0.
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= CH_W'(NUM_CH - 1);
    else if (state == IDLE && grant_any)
      last_grant <= grant_ch;
  end
`else
  always_comb begin
    grant_any = |eligible;
    grant_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (eligible[i]) grant_ch = CH_W'(i);
  end
`endif

  assign win_addr  = req_addr [int'(grant_ch)*ADDR_W  +: ADDR_W];
  assign win_rmask = req_rmask[int'(grant_ch)*MASK_W  +: MASK_W];
  assign win_wmask = req_wmask[int'(grant_ch)*MASK_W  +: MASK_W];
  assign win_wdata = req_wdata[int'(grant_ch)*DATA_W  +: DATA_W];
  assign win_order = req_order[int'(grant_ch)*ORDER_W +: ORDER_W];

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (!rst && state == IDLE && grant_any)    req_ready[grant_ch] = 1'b1;
    if (!rst && state == RESP && !cap_flushed) resp_valid[cap_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_ch     <= '0;
      cap_store  <= 1'b0;
      cap_order  <= '0;
      resp_rdata <= '0;
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
    end else begin
      // Any memory response while a transaction is open closes the port.
      if ((state == WAIT || state == SQUASH) && dmem_resp) begin
        dmem_addr  <= '0;
        dmem_rmask <= '0;
        dmem_wmask <= '0;
        dmem_wdata <= '0;
      end
      case (state)
        IDLE: if (grant_any) begin
          dmem_addr  <= win_addr;
          dmem_rmask <= (|win_wmask) ? '0 : win_rmask;
          dmem_wmask <= win_wmask;
          dmem_wdata <= win_wdata;
          cap_ch     <= grant_ch;
          cap_store  <= |win_wmask;
          cap_order  <= win_order;
          state      <= WAIT;
        end
        WAIT: begin
          if (cap_flushed) begin
            state <= dmem_resp ? IDLE : SQUASH;
          end else if (dmem_resp) begin
            resp_rdata <= cap_store ? '0 : dmem_rdata;
            state      <= RESP;
          end
        end
        SQUASH: if (dmem_resp) state <= IDLE;
        RESP: begin
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter_n.sv
// Randomized and directed bench for mem_access_arbiter_n against a transaction-level model.
module tb_mem_access_arbiter_n;
  localparam int NUM_CH = 3, ADDR_W = 32, DATA_W = 32, ORDER_W = 64, MASK_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]         req_valid, req_ready, resp_valid;
  logic [NUM_CH*ADDR_W-1:0]  req_addr;
  logic [NUM_CH*MASK_W-1:0]  req_rmask, req_wmask;
  logic [NUM_CH*DATA_W-1:0]  req_wdata;
  logic [NUM_CH*ORDER_W-1:0] req_order;
  logic [DATA_W-1:0]         resp_rdata, dmem_wdata, dmem_rdata;
  logic [ORDER_W-1:0]        resp_order, flush_order;
  logic                      flush_valid, dmem_resp, busy;
  logic [ADDR_W-1:0]         dmem_addr;
  logic [MASK_W-1:0]         dmem_rmask, dmem_wmask;

  logic [ADDR_W-1:0]  r_addr [NUM_CH];
  logic [MASK_W-1:0]  r_rmask[NUM_CH];
  logic [MASK_W-1:0]  r_wmask[NUM_CH];
  logic [DATA_W-1:0]  r_wdata[NUM_CH];
  logic [ORDER_W-1:0] r_order[NUM_CH];

  always_comb begin
    req_addr = '0; req_rmask = '0; req_wmask = '0; req_wdata = '0; req_order = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_addr [i*ADDR_W  +: ADDR_W]  = r_addr[i];
      req_rmask[i*MASK_W  +: MASK_W]  = r_rmask[i];
      req_wmask[i*MASK_W  +: MASK_W]  = r_wmask[i];
      req_wdata[i*DATA_W  +: DATA_W]  = r_wdata[i];
      req_order[i*ORDER_W +: ORDER_W] = r_order[i];
    end
  end

  mem_access_arbiter_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ORDER_W(ORDER_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_rmask(req_rmask), .req_wmask(req_wmask),
    .req_wdata(req_wdata), .req_order(req_order),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_order(resp_order),
    .flush_valid(flush_valid), .flush_order(flush_order),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .busy(busy)
  );

  int checks = 0, failures = 0;

  // Model: one open memory transaction (possibly doomed by a flush) and one pending response.
  bit                 m_open, m_pend, m_dead;
  int                 m_ch, rr_next, last_grant_m, mem_cnt, lat_max;
  logic [ADDR_W-1:0]  m_addr;
  logic [MASK_W-1:0]  m_rmask, m_wmask;
  logic [DATA_W-1:0]  m_wdata, m_rdata;
  logic [ORDER_W-1:0] m_order;
  bit                 auto_mem, auto_drop;
  int                 exp_seq[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pick();
    int start, idx;
`ifdef ARB_ROUND_ROBIN_EN
    start = rr_next;
`else
    start = 0;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (start + k) % NUM_CH;
      if (req_valid[idx] && !(flush_valid && r_order[idx] > flush_order)) return idx;
    end
    return -1;
  endfunction

  task automatic compare();
    logic [NUM_CH-1:0] exp_rdy, exp_rv;
    int w;
    exp_rdy = '0; exp_rv = '0;
    if (!rst && !m_open && !m_pend) begin
      w = pick();
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    if (!rst && m_pend && !(flush_valid && m_order > flush_order)) exp_rv[m_ch] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("resp_valid", resp_valid, exp_rv);
    chk("busy", busy, m_open || m_pend);
    chk("dmem_addr", dmem_addr, m_open ? m_addr : '0);
    chk("dmem_rmask", dmem_rmask, m_open ? m_rmask : '0);
    chk("dmem_wmask", dmem_wmask, m_open ? m_wmask : '0);
    chk("dmem_wdata", dmem_wdata, m_open ? m_wdata : '0);
    if (m_pend) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_order", resp_order, m_order);
    end
  endtask

  task automatic model_step();
    int w;
    last_grant_m = -1;
    if (rst) begin
      m_open = 0; m_pend = 0; m_dead = 0; rr_next = 0;
    end else if (m_pend) begin
      m_pend = 0;
    end else if (m_open) begin
      if (flush_valid && m_order > flush_order) m_dead = 1;
      if (dmem_resp) begin
        m_open = 0;
        if (!m_dead) begin
          m_pend  = 1;
          m_rdata = (m_wmask != 0) ? '0 : dmem_rdata;
        end
      end
    end else begin
      w = pick();
      if (w >= 0) begin
        m_open = 1; m_dead = 0; m_ch = w;
        m_addr = r_addr[w]; m_wmask = r_wmask[w]; m_wdata = r_wdata[w]; m_order = r_order[w];
        m_rmask = (r_wmask[w] != 0) ? '0 : r_rmask[w];
        rr_next = (w + 1) % NUM_CH;
        last_grant_m = w;
        mem_cnt = $urandom_range(0, lat_max);
      end
    end
  endtask

  task automatic drive_mem();
    dmem_resp = 1'b0;
    dmem_rdata = '0;
    if (m_open) begin
      if (mem_cnt == 0) begin dmem_resp = 1'b1; dmem_rdata = $urandom; end
      else mem_cnt--;
    end else if ($urandom_range(0, 7) == 0) begin
      dmem_resp = 1'b1; dmem_rdata = $urandom;
    end
  endtask

  task automatic begin_cycle();
    if (auto_mem) drive_mem();
    @(negedge clk);
    compare();
  endtask

  task automatic end_cycle();
    @(posedge clk); #1;
    model_step();
    if (auto_drop && last_grant_m >= 0) req_valid[last_grant_m] = 1'b0;
    if (!auto_mem) begin dmem_resp = 1'b0; dmem_rdata = '0; end
  endtask

  task automatic set_req(input int ch, input logic [31:0] a, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] wd, input logic [63:0] o);
    req_valid[ch] = 1'b1;
    r_addr[ch] = a; r_rmask[ch] = rm; r_wmask[ch] = wm; r_wdata[ch] = wd; r_order[ch] = o;
  endtask

  task automatic drain(input int n);
    auto_mem = 1; lat_max = 2; auto_drop = 1;
    repeat (n) begin begin_cycle(); end_cycle(); end
  endtask

  initial begin
    int got;
    rst = 1'b1; req_valid = '0; flush_valid = 1'b0; flush_order = '0;
    dmem_resp = 1'b0; dmem_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      r_addr[i] = '0; r_rmask[i] = '0; r_wmask[i] = '0; r_wdata[i] = '0; r_order[i] = '0;
    end
    m_open = 0; m_pend = 0; m_dead = 0; m_ch = 0; rr_next = 0; mem_cnt = 0; lat_max = 0;
    auto_mem = 0; auto_drop = 1;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    repeat (2) begin @(posedge clk); #1; model_step(); end
    rst = 1'b0;

    begin_cycle();
    chk("rst_busy", busy, 0); chk("rst_dmem_addr", dmem_addr, 0); chk("rst_req_ready", req_ready, 0);
    end_cycle();

    // Load on ch1, memory answers three cycles after the request appears.
    set_req(1, 32'h100, 4'hF, 4'h0, 32'h0, 64'd5);
    begin_cycle(); chk("t1_grant", req_ready, 3'b010); end_cycle();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      begin_cycle(); chk("t1_dmem_addr", dmem_addr, 32'h100); chk("t1_no_resp", resp_valid, 0); end_cycle();
    end
    begin_cycle();
    chk("t1_resp_valid", resp_valid, 3'b010); chk("t1_rdata", resp_rdata, 32'hDEADBEEF); chk("t1_order", resp_order, 5);
    end_cycle();

    // Contention with all channels held valid, after a fresh reset.
    rst = 1'b1; begin_cycle(); end_cycle(); rst = 1'b0;
    auto_drop = 0; auto_mem = 1; lat_max = 0;
    for (int i = 0; i < NUM_CH; i++) set_req(i, 32'h10 * (i + 1), 4'hF, 4'h0, 32'h0, 64'd1);
    for (int g = 0; g < 4; g++) begin
      got = -1;
      for (int c = 0; c < 12 && got < 0; c++) begin
        begin_cycle();
        for (int i = 0; i < NUM_CH; i++) if (req_ready[i]) got = i;
        end_cycle();
      end
      chk("t2_grant_seq", got, exp_seq[g]);
    end
    req_valid = '0;
    drain(8);

    // Store with both masks set: rmask must be dropped and rdata returned as 0.
    auto_mem = 0;
    set_req(2, 32'h40, 4'hF, 4'h3, 32'h1234, 64'd2);
    begin_cycle(); chk("t3_grant", req_ready, 3'b100); end_cycle();
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    begin_cycle();
    chk("t3_wmask", dmem_wmask, 4'h3); chk("t3_wdata", dmem_wdata, 32'h1234); chk("t3_rmask", dmem_rmask, 0);
    end_cycle();
    begin_cycle(); chk("t3_resp_valid", resp_valid, 3'b100); chk("t3_rdata", resp_rdata, 0); end_cycle();

    // Flush of an in-flight younger load: memory completes, no response.
    set_req(0, 32'h200, 4'hF, 4'h0, 32'h0, 64'd9);
    begin_cycle(); end_cycle();
    flush_valid = 1'b1; flush_order = 64'd7;
    begin_cycle(); chk("t4_addr_a", dmem_addr, 32'h200); end_cycle();
    flush_valid = 1'b0;
    begin_cycle(); chk("t4_addr_b", dmem_addr, 32'h200); chk("t4_busy_a", busy, 1); end_cycle();
    dmem_resp = 1'b1; dmem_rdata = 32'h5555;
    begin_cycle(); chk("t4_busy_b", busy, 1); chk("t4_no_resp_a", resp_valid, 0); end_cycle();
    begin_cycle(); chk("t4_busy_c", busy, 0); chk("t4_no_resp_b", resp_valid, 0); end_cycle();

    // Flush filtering of eligibility in IDLE, including an unsigned top-bit order.
    flush_valid = 1'b1; flush_order = 64'd4;
    set_req(0, 32'h300, 4'hF, 4'h0, 32'h0, 64'd6);
    set_req(1, 32'h304, 4'hF, 4'h0, 32'h0, 64'd3);
    begin_cycle(); chk("t5_grant", req_ready, 3'b010); end_cycle();
    flush_valid = 1'b0;
    drain(10);
    flush_valid = 1'b1; flush_order = 64'd1;
    set_req(0, 32'h310, 4'hF, 4'h0, 32'h0, 64'h8000_0000_0000_0000);
    set_req(2, 32'h314, 4'hF, 4'h0, 32'h0, 64'd1);
    begin_cycle(); chk("t5_unsigned", req_ready, 3'b100); end_cycle();
    flush_valid = 1'b0;
    drain(10);

    // Reset in WAIT abandons the transaction; a stray response is ignored.
    auto_mem = 0;
    set_req(0, 32'h400, 4'hF, 4'h0, 32'h0, 64'd1);
    begin_cycle(); chk("t6_grant", req_ready, 3'b001); end_cycle();
    rst = 1'b1;
    begin_cycle(); end_cycle();
    rst = 1'b0;
    dmem_resp = 1'b1; dmem_rdata = 32'hABCD;
    begin_cycle();
    chk("t6_addr", dmem_addr, 0); chk("t6_busy", busy, 0); chk("t6_ready", req_ready, 0); chk("t6_rv_a", resp_valid, 0);
    end_cycle();
    begin_cycle(); chk("t6_rv_b", resp_valid, 0); end_cycle();

    // Randomized traffic checked every cycle against the model.
    auto_mem = 1; lat_max = 4; auto_drop = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, $urandom, 4'($urandom), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), $urandom,
                  {($urandom_range(0, 9) == 0), 59'd0, 4'($urandom)});
        end
      end
      flush_valid = ($urandom_range(0, 6) == 0);
      flush_order = 64'($urandom_range(0, 15));
      begin_cycle(); end_cycle();
    end
    req_valid = '0; flush_valid = 1'b0;
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
